// File: rtl/transpose_rotate_seq_pkg.sv
// Shared types and default geometry for the transpose rotation sequencer.
// Geometry is 8 lanes of 3 bits unless the top is overridden.
package transpose_pkg;

    localparam int DATA_WIDTH     = 3;
    localparam int NUM_PE         = 8;
    localparam int TOTAL_WIDTH    = DATA_WIDTH * NUM_PE;
    localparam int SHIFT_AMT_BITS = $clog2(TOTAL_WIDTH);
    localparam int IDX_BITS       = $clog2(NUM_PE);

    typedef enum logic {ROT_PRE, ROT_POST} rot_mode_e;
    typedef enum logic {S_IDLE, S_ACTIVE} seq_state_e;

    // Rotating right moves lane (i + k) down to lane i.
    localparam bit SHIFT_RIGHT = 1'b0;
    localparam bit SHIFT_LEFT  = 1'b1;

endpackage

// File: rtl/transpose_rotate_seq_if.sv
// Row stream bundle: input rows, rotated output rows and status.
// master drives rows in and accepts rows out; slave is the sequencer.
interface transpose_rotate_seq_if
    import transpose_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int NP = NUM_PE
);
    localparam int TW = DW * NP;
    localparam int IW = $clog2(NP);

    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_row;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_row;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    modport master (
        output mode, in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_idx, out_last, busy
    );

    modport slave (
        input  mode, in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_idx, out_last, busy
    );

endinterface

// File: rtl/transpose_rotate_seq_circular_shift.sv
// Combinational barrel rotator over a WIDTH-bit word.
// SHIFT_DIR 0 rotates toward bit 0, 1 rotates toward the MSB.
module circular_shift #(
    parameter int WIDTH     = 24,
    parameter bit SHIFT_DIR = 1'b0
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] amt,
    output logic [WIDTH-1:0]         result
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] sh;

    assign dbl = {data, data};

    generate
        if (SHIFT_DIR == 1'b0) begin : g_right
            assign sh     = dbl >> amt;
            assign result = sh[WIDTH-1:0];
        end else begin : g_left
            assign sh     = dbl << amt;
            assign result = sh[2*WIDTH-1:WIDTH];
        end
    endgenerate

endmodule

// File: rtl/transpose_rotate_seq.sv
// Row sequencer: rotates each row of a matrix by a row-dependent lane
// count and presents it through a one-entry registered output stage.
module transpose_rotate_seq
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = transpose_pkg::DATA_WIDTH,
    parameter int NUM_PE     = transpose_pkg::NUM_PE
) (
    input  logic                   clk,
    input  logic                   rst,
    transpose_rotate_seq_if.slave  io
);

    localparam int TW    = DATA_WIDTH * NUM_PE;
    localparam int AMT_W = $clog2(TW);
    localparam int IW    = $clog2(NUM_PE);

    localparam logic [IW-1:0]    LAST_ROW = IW'(NUM_PE - 1);
    localparam logic [IW-1:0]    NP_IDX   = IW'(NUM_PE);
    localparam logic [AMT_W-1:0] DW_AMT   = AMT_W'(DATA_WIDTH);

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [IW-1:0]    row_cnt;
    logic [IW-1:0]    row_cnt_nxt;
    rot_mode_e        mode_q;
    rot_mode_e        mode_eff;
    logic [IW-1:0]    k;
    logic [AMT_W-1:0] amt;
    logic [TW-1:0]    rot_row;
    logic             in_xfer;
    logic             out_xfer;

    assign io.in_ready = !io.out_valid || io.out_ready;
    assign in_xfer     = io.in_valid && io.in_ready;
    assign out_xfer    = io.out_valid && io.out_ready;
    assign io.busy     = (row_cnt != '0);

    // Row 0 takes the live mode; later rows use the latched one.
    assign mode_eff = (state == S_IDLE) ? rot_mode_e'(io.mode) : mode_q;

    always_comb begin
        k = row_cnt;
        if (mode_eff == ROT_POST && row_cnt != '0) begin
            k = NP_IDX - row_cnt;
        end
    end

    assign amt = AMT_W'(k) * DW_AMT;

    circular_shift #(
        .WIDTH     (TW),
        .SHIFT_DIR (SHIFT_RIGHT)
    ) u_shift (
        .data   (io.in_row),
        .amt    (amt),
        .result (rot_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        unique case (state)
            S_IDLE: begin
                if (in_xfer) begin
                    state_nxt   = S_ACTIVE;
                    row_cnt_nxt = IW'(1);
                end
            end
            S_ACTIVE: begin
                if (in_xfer) begin
                    if (row_cnt == LAST_ROW) begin
                        state_nxt   = S_IDLE;
                        row_cnt_nxt = '0;
                    end else begin
                        row_cnt_nxt = row_cnt + IW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= ROT_PRE;
        end else if (in_xfer && state == S_IDLE) begin
            mode_q <= rot_mode_e'(io.mode);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.out_valid <= 1'b0;
            io.out_row   <= '0;
            io.out_idx   <= '0;
            io.out_last  <= 1'b0;
        end else if (in_xfer) begin
            io.out_valid <= 1'b1;
            io.out_row   <= rot_row;
            io.out_idx   <= row_cnt;
            io.out_last  <= (row_cnt == LAST_ROW);
        end else if (out_xfer) begin
            io.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_transpose_rotate_seq.sv
// Scoreboard bench for transpose_rotate_seq: a lane-level model queues
// expected rows on every accepted input and compares on every output.
module tb_transpose_rotate_seq;
    import transpose_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int NP = NUM_PE;
    localparam int TW = TOTAL_WIDTH;
    localparam int IW = IDX_BITS;

    typedef struct packed {
        logic [TW-1:0] row;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    transpose_rotate_seq_if #(.DW(DW), .NP(NP)) bus();

    transpose_rotate_seq #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    exp_t          sb[$];
    logic [TW-1:0] got_rows[$];
    logic [IW-1:0] got_idx[$];
    logic          got_last[$];
    int            got_cyc[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            tb_cnt = 0;
    logic          tb_mode = 1'b0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] rotate(logic [TW-1:0] row, int k);
        logic [TW-1:0] o;
        o = '0;
        for (int i = 0; i < NP; i++) begin
            o[i*DW +: DW] = row[((i + k) % NP)*DW +: DW];
        end
        return o;
    endfunction

    function automatic logic [TW-1:0] seq_row(int s);
        logic [TW-1:0] o;
        o = '0;
        for (int i = 0; i < NP; i++) begin
            o[i*DW +: DW] = DW'((i + s) % NP);
        end
        return o;
    endfunction

    function automatic logic [TW-1:0] rand_row();
        logic [TW-1:0] o;
        o = '0;
        for (int i = 0; i < NP; i++) begin
            o[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
        end
        return o;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_row", bus.out_row, e.row);
                    check("out_idx", bus.out_idx, e.idx);
                    check("out_last", bus.out_last, e.last);
                end
                got_rows.push_back(bus.out_row);
                got_idx.push_back(bus.out_idx);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                if (tb_cnt == 0) tb_mode = bus.mode;
                if (tb_cnt == 0) k = 0;
                else if (tb_mode) k = NP - tb_cnt;
                else k = tb_cnt;
                e.row  = rotate(bus.in_row, k);
                e.idx  = IW'(tb_cnt);
                e.last = (tb_cnt == NP - 1);
                sb.push_back(e);
                tb_cnt = (tb_cnt + 1) % NP;
            end
        end
        cyc++;
    end

    task automatic send(logic [TW-1:0] row, logic m);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        bus.mode     = m;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 100);
        if (!bus.in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_rows.delete();
        got_idx.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [TW-1:0] r2;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_row", bus.out_row, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic pre-rotation
        clear_log();
        for (int r = 0; r < NP; r++) begin
            send(seq_row(0), 1'b0);
            if (r == 0) check("busy_rise", bus.busy, 1);
        end
        drain();
        check("basic_busy_low", bus.busy, 0);
        check("basic_count", got_rows.size(), NP);
        check("basic_row5", got_rows[5], seq_row(5));
        check("basic_last7", got_last[7], 1);

        // post-rotation
        clear_log();
        for (int r = 0; r < NP; r++) send(seq_row(0), 1'b1);
        drain();
        check("post_row0", got_rows[0], seq_row(0));
        check("post_row5", got_rows[5], seq_row(3));
        check("post_row1", got_rows[1], seq_row(7));

        // backpressure after row 2
        clear_log();
        r2 = '0;
        for (int r = 0; r < 3; r++) begin
            r2 = rand_row();
            send(r2, 1'b0);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_row    = rand_row();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_idx", bus.out_idx, 2);
            check("bp_out_row", bus.out_row, rotate(r2, 2));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int r = 3; r < NP; r++) send(rand_row(), 1'b0);
        drain();
        check("bp_count", got_rows.size(), NP);

        // mode toggled after row 0, then next matrix in new mode
        clear_log();
        send(seq_row(0), 1'b0);
        for (int r = 1; r < NP; r++) send(seq_row(0), 1'b1);
        for (int r = 0; r < NP; r++) send(seq_row(0), 1'b1);
        drain();
        check("mc_row3", got_rows[3], seq_row(3));
        check("mc_next_row1", got_rows[NP+1], seq_row(7));

        // asynchronous reset after row 4
        for (int r = 0; r < 5; r++) send(rand_row(), 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_row", bus.out_row, 0);
        check("mid_rst_out_idx", bus.out_idx, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        sb.delete();
        tb_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        for (int r = 0; r < NP; r++) send(seq_row(0), 1'b0);
        drain();
        check("post_rst_idx0", got_idx[0], 0);
        check("post_rst_row0", got_rows[0], seq_row(0));

        // back-to-back matrices
        clear_log();
        for (int r = 0; r < 2*NP; r++) send(rand_row(), r >= NP);
        drain();
        check("b2b_count", got_rows.size(), 2*NP);
        check("b2b_no_bubble", got_cyc[2*NP-1] - got_cyc[0], 2*NP - 1);
        check("b2b_last_a", got_last[NP-1], 1);
        check("b2b_mid", got_last[NP], 0);
        check("b2b_last_b", got_last[2*NP-1], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/transpose_rotate_seq.md
# transpose_rotate_seq

Row-streaming sequencer for the matrix-transpose datapath. It accepts one NUM_PE x DATA_WIDTH matrix as NUM_PE consecutive rows over a valid/ready handshake. Each row is rotated by a lane amount derived from its row index and the matrix mode, using a `circular_shift` instance. The rotated row is emitted through a one-entry registered output stage. The block sits between the row buffer and the column-permutation stage, and performs the pre-rotation or post-rotation pass of the rotate-permute-rotate transpose.

## Interface
Parameters:
- DATA_WIDTH, 3, bits per matrix element (one lane)
- NUM_PE, 8, lanes per row and rows per matrix (must be at least 2)

Ports:
- clk  in  1  single clock; all state is updated on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = pre-rotation (k = r), 1 = post-rotation (k = (NUM_PE - r) mod NUM_PE); sampled only on the row-0 transfer
- in_valid  in  1  in_row is valid
- in_ready  out  1  block accepts in_row this cycle
- in_row  in  NUM_PE*DATA_WIDTH  lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- out_valid  out  1  out_row is valid
- out_ready  in  1  downstream accepts out_row
- out_row  out  NUM_PE*DATA_WIDTH  rotated row
- out_idx  out  $clog2(NUM_PE)  row index r of out_row
- out_last  out  1  out_row is row NUM_PE-1 of the matrix
- busy  out  1  a matrix is partially accepted (row_cnt != 0)

## Operation
- **FSM states**
  - IDLE: row_cnt = 0 and no mode is latched.
  - ACTIVE: the mode is latched and row_cnt is in 1..NUM_PE-1.
- **Input transfer:** occurs when in_valid && in_ready.
  - In IDLE, a transfer latches `mode` into mode_q, computes k from r = 0, and moves to ACTIVE.
  - In ACTIVE, each transfer increments row_cnt.
  - The transfer of row NUM_PE-1 returns the FSM to IDLE with row_cnt = 0.
- **Mode sampling:** `mode` is ignored while ACTIVE. Row 0 uses the live `mode` input, not mode_q.
- **Rotation amount:** k = r for mode 0; k = (NUM_PE - r) mod NUM_PE for mode 1. Row 0 always gets k = 0.
- **Lane mapping:** out_row lane i = in_row lane (i + k) mod NUM_PE.
  - The shifter bit amount is k*DATA_WIDTH, width $clog2(NUM_PE*DATA_WIDTH).
  - The maximum value is (NUM_PE-1)*DATA_WIDTH < TOTAL_WIDTH, so the amount never wraps.
  - SHIFT_DIR is fixed to the direction that realises this mapping.
- **Output register:** out_row, out_idx and out_last are loaded on every input transfer.
- **out_valid:**
  - set on an input transfer;
  - cleared on an output transfer (out_valid && out_ready) that has no simultaneous input transfer;
  - held on a simultaneous input and output transfer.
- **in_ready** = !out_valid || out_ready. This gives full throughput of one row per cycle with no bubble.
- **Output hold:** while out_valid && !out_ready, out_row, out_idx and out_last hold stable and in_ready = 0.
- **Back-to-back matrices:** row 0 of the next matrix may be accepted in the cycle after the row NUM_PE-1 transfer, with no idle gap.
- **Reset mid-matrix:** the partial matrix is discarded. No out_last is ever produced for it.

## Timing
- **Reset values:** out_valid = 0, out_row = 0, out_idx = 0, out_last = 0, busy = 0, in_ready = 1, row_cnt = 0, mode_q = 0, FSM = IDLE.
- **Latency:** an input transfer at edge n gives out_valid = 1 with data from edge n onward. The rotation is combinational before the register, so there is one register stage.
- **Throughput:** one row per cycle while out_ready = 1.
- **busy:** rises the cycle after the row-0 transfer and falls the cycle after the row NUM_PE-1 transfer.
- **Combinational paths:** in_ready depends combinationally on out_ready. There is no combinational path from in_valid or in_row to any output.

## Structure
- **Package transpose_pkg:**
  - DATA_WIDTH, NUM_PE, TOTAL_WIDTH = DATA_WIDTH*NUM_PE, SHIFT_AMT_BITS = $clog2(TOTAL_WIDTH), IDX_BITS = $clog2(NUM_PE);
  - typedef enum logic {ROT_PRE, ROT_POST} rot_mode_e;
  - typedef enum logic {S_IDLE, S_ACTIVE} seq_state_e.
- **Sub-module:** one existing combinational `circular_shift` (TOTAL_WIDTH, SHIFT_DIR) instantiated once. The counter, FSM and output stage stay in this module.

## Test plan
Defaults throughout: DATA_WIDTH = 3, NUM_PE = 8; lanes listed from lane 0 upward.
- **Basic streaming:** reset released, out_ready = 1, mode = 0, 8 rows each with lanes 0..7 = 0,1,…,7.
  - out_idx = 0..7 on consecutive cycles; row 5 gives lanes 5,6,7,0,1,2,3,4.
  - out_last = 1 only with idx 7; busy is low after the last row.
- **Post-rotation:** mode = 1, same rows.
  - Row 0 is unchanged; row 5 (k = 3) gives 3,4,5,6,7,0,1,2; row 1 (k = 7) gives 7,0,1,2,3,4,5,6.
- **Backpressure:** out_ready = 0 for 4 cycles after row 2 is accepted.
  - in_ready = 0 and out_row/out_idx hold at idx 2 for those cycles.
  - Resume with no lost or duplicated rows.
- **Mode change mid-matrix:** toggle mode after row 0 (mode = 0).
  - Rows 1..7 still use k = r; the next matrix picks up the new mode at its row 0.
- **Reset mid-matrix:** assert rst asynchronously after row 4.
  - All outputs go to reset values immediately; the next row accepted has out_idx = 0.
- **Back-to-back matrices:** two matrices with in_valid = 1 continuously and out_ready = 1.
  - 16 consecutive output cycles, out_last at cycles 8 and 16, no bubble.
